// File: rtl/multicycle_cu_if.sv
// ============================================================================
// Module      : multicycle_cu_if
// Description : Datapath-facing bundle of the multicycle MIPS control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_cu_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Opcode;
    logic [5:0]       Funct;
    logic             Zero;
    logic             InsReady;
    logic             DataReady;

    logic             InsReq;
    logic             DataReq;
    logic             IRWrite;
    logic             PCWrite;
    logic [1:0]       PCSrc;
    logic             RegWrite;
    logic [1:0]       RegDst;
    logic [1:0]       MemToReg;
    logic             MemRead;
    logic             MemWrite;
    logic             ALUSrcA;
    logic             ALUSrcB;
    logic             ExtSel;
    logic [2:0]       ALUOp;
    logic [2:0]       State;
    logic             Halted;
    logic             Error;
    logic [CNT_W-1:0] InsCount;
    logic [CNT_W-1:0] CycleCount;

    modport master (
        input  Opcode, Funct, Zero, InsReady, DataReady,
        output InsReq, DataReq, IRWrite, PCWrite, PCSrc, RegWrite, RegDst,
               MemToReg, MemRead, MemWrite, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
               State, Halted, Error, InsCount, CycleCount
    );

    modport slave (
        output Opcode, Funct, Zero, InsReady, DataReady,
        input  InsReq, DataReq, IRWrite, PCWrite, PCSrc, RegWrite, RegDst,
               MemToReg, MemRead, MemWrite, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
               State, Halted, Error, InsCount, CycleCount
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_cu.sv
// ============================================================================
// Module      : multicycle_cu
// Description : IF/ID/EXE/MEM/WB sequencer with memory timeouts and counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_cu #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  wire logic       CLK,
    input  wire logic       Reset,
    multicycle_cu_if.master bus
);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000,
                           OP_ORI   = 6'b001101, OP_LW   = 6'b100011,
                           OP_SW    = 6'b101011, OP_BEQ  = 6'b000100,
                           OP_BNE   = 6'b000101, OP_J    = 6'b000010,
                           OP_JAL   = 6'b000011, OP_HALT = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010,
                           FN_AND = 6'b100100, FN_OR  = 6'b100101,
                           FN_SLT = 6'b101010, FN_SLL = 6'b000000;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_OR  = 3'b011, ALU_SLT = 3'b100, ALU_SLL = 3'b101;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t            state, state_next;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_next;
    logic [CNT_W-1:0]  ins_cnt, cyc_cnt;

    logic       is_r, r_known, taken;
    logic [2:0] dec_alu_op;
    logic       dec_src_a, dec_src_b, dec_ext;

    logic       ins_req, data_req, ir_write, pc_write, reg_write;
    logic       mem_read, mem_write, alu_src_a, alu_src_b, ext_sel;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
    logic [2:0] alu_op;

    // ALU controls depend only on the instruction; EXE and MEM both present them.
    always_comb begin
        is_r       = (bus.Opcode == OP_RTYPE);
        r_known    = 1'b1;
        dec_alu_op = ALU_ADD;
        dec_src_a  = 1'b0;
        dec_src_b  = 1'b0;
        dec_ext    = 1'b1;
        taken      = (bus.Opcode == OP_BEQ) ? bus.Zero : ~bus.Zero;
        if (is_r) begin
            case (bus.Funct)
                FN_ADD:  dec_alu_op = ALU_ADD;
                FN_SUB:  dec_alu_op = ALU_SUB;
                FN_AND:  dec_alu_op = ALU_AND;
                FN_OR:   dec_alu_op = ALU_OR;
                FN_SLT:  dec_alu_op = ALU_SLT;
                FN_SLL: begin
                    dec_alu_op = ALU_SLL;
                    dec_src_a  = 1'b1;
                end
                default: r_known = 1'b0;
            endcase
        end else begin
            case (bus.Opcode)
                OP_ADDI, OP_LW, OP_SW: dec_src_b = 1'b1;
                OP_ORI: begin
                    dec_alu_op = ALU_OR;
                    dec_src_b  = 1'b1;
                    dec_ext    = 1'b0;
                end
                OP_BEQ, OP_BNE: dec_alu_op = ALU_SUB;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        ins_req    = 1'b0;
        data_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        ext_sel    = 1'b0;
        alu_op     = 3'b000;
        case (state)
            S_IF: begin
                ins_req = 1'b1;
                if (bus.InsReady) begin
                    ir_write   = 1'b1;
                    state_next = S_ID;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_ERR;
                end
            end
            S_ID: begin
                case (bus.Opcode)
                    OP_HALT: state_next = S_HALT;
                    OP_J: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'b10;
                        state_next = S_IF;
                    end
                    OP_JAL: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'b10;
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                        state_next = S_IF;
                    end
                    OP_RTYPE: state_next = r_known ? S_EXE : S_ERR;
                    OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_next = S_EXE;
                    default: state_next = S_ERR;
                endcase
            end
            S_EXE: begin
                alu_op    = dec_alu_op;
                alu_src_a = dec_src_a;
                alu_src_b = dec_src_b;
                ext_sel   = dec_ext;
                case (bus.Opcode)
                    OP_BEQ, OP_BNE: begin
                        pc_write   = 1'b1;
                        pc_src     = taken ? 2'b01 : 2'b00;
                        state_next = S_IF;
                    end
                    OP_LW, OP_SW: state_next = S_MEM;
                    default:      state_next = S_WB;
                endcase
            end
            S_MEM: begin
                alu_op    = dec_alu_op;
                alu_src_a = dec_src_a;
                alu_src_b = dec_src_b;
                ext_sel   = dec_ext;
                data_req  = 1'b1;
                mem_read  = (bus.Opcode == OP_LW);
                mem_write = (bus.Opcode == OP_SW);
                if (bus.DataReady) begin
                    if (bus.Opcode == OP_LW) begin
                        state_next = S_WB;
                    end else begin
                        pc_write   = 1'b1;
                        state_next = S_IF;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_ERR;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                reg_dst    = is_r ? 2'b01 : 2'b00;
                mem_to_reg = (bus.Opcode == OP_LW) ? 2'b01 : 2'b00;
                state_next = S_IF;
            end
            default: ;
        endcase

        // Any state change clears the wait counter, so IF and MEM always start at 0.
        if (state_next != state) begin
            wait_cnt_next = '0;
        end else if ((state == S_IF && !bus.InsReady) || (state == S_MEM && !bus.DataReady)) begin
            wait_cnt_next = wait_cnt + 1'b1;
        end else begin
            wait_cnt_next = wait_cnt;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= S_IF;
            wait_cnt <= '0;
            ins_cnt  <= '0;
            cyc_cnt  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (pc_write && ins_cnt != {CNT_W{1'b1}}) begin
                ins_cnt <= ins_cnt + 1'b1;
            end
            if (state != S_HALT && state != S_ERR && cyc_cnt != {CNT_W{1'b1}}) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    // Reset masks every output so an abandoned instruction cannot commit.
    always_comb begin
        bus.InsReq     = ins_req   & ~Reset;
        bus.DataReq    = data_req  & ~Reset;
        bus.IRWrite    = ir_write  & ~Reset;
        bus.PCWrite    = pc_write  & ~Reset;
        bus.RegWrite   = reg_write & ~Reset;
        bus.MemRead    = mem_read  & ~Reset;
        bus.MemWrite   = mem_write & ~Reset;
        bus.ALUSrcA    = alu_src_a & ~Reset;
        bus.ALUSrcB    = alu_src_b & ~Reset;
        bus.ExtSel     = ext_sel   & ~Reset;
        bus.PCSrc      = Reset ? 2'b00 : pc_src;
        bus.RegDst     = Reset ? 2'b00 : reg_dst;
        bus.MemToReg   = Reset ? 2'b00 : mem_to_reg;
        bus.ALUOp      = Reset ? 3'b000 : alu_op;
        bus.State      = Reset ? 3'b000 : state;
        bus.Halted     = ~Reset & (state == S_HALT);
        bus.Error      = ~Reset & (state == S_ERR);
        bus.InsCount   = Reset ? '0 : ins_cnt;
        bus.CycleCount = Reset ? '0 : cyc_cnt;
    end
endmodule

`default_nettype wire

// File: tb/tb_multicycle_cu.sv
// ============================================================================
// Module      : tb_multicycle_cu
// Description : Directed scoreboard bench for multicycle_cu (plus a 3-bit counter copy).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_cu;
    localparam int TIMEOUT = 4;
    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3,
                           S_WB = 3'd4, S_HALT = 3'd5, S_ERR = 3'd6;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, ORR = 3'b011, SLL = 3'b101;
    localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LW = 6'b100011,
                           OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                           OP_J = 6'b000010, OP_JAL = 6'b000011, OP_HALT = 6'b111111;

    typedef struct packed {
        logic       ins_req, data_req, ir_write, pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       mem_read, mem_write, alu_src_a, alu_src_b, ext_sel;
        logic [2:0] alu_op, state;
        logic       halted, error;
    } ctl_t;

    typedef struct {
        ctl_t        ctl;
        logic [31:0] ins, cyc;
        logic [2:0]  ins3, cyc3;
    } exp_t;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, ins_ready = 1'b0, data_ready = 1'b0;

    always #5 CLK = ~CLK;

    multicycle_cu_if #(.CNT_W(32)) bm();
    multicycle_cu_if #(.CNT_W(3))  bs();

    assign bm.Opcode = opcode;     assign bs.Opcode = opcode;
    assign bm.Funct = funct;       assign bs.Funct = funct;
    assign bm.Zero = zero;         assign bs.Zero = zero;
    assign bm.InsReady = ins_ready;   assign bs.InsReady = ins_ready;
    assign bm.DataReady = data_ready; assign bs.DataReady = data_ready;

    multicycle_cu #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (.CLK(CLK), .Reset(Reset), .bus(bm));
    multicycle_cu #(.TIMEOUT(TIMEOUT), .CNT_W(3))  dut_sat (.CLK(CLK), .Reset(Reset), .bus(bs));

    exp_t        sb_q[$];
    string       tag_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_ins = 0, m_cyc = 0;
    logic [2:0]  m_ins3 = 0, m_cyc3 = 0;
    ctl_t        e;

    function automatic ctl_t observed();
        ctl_t o;
        o.ins_req = bm.InsReq;     o.data_req = bm.DataReq;   o.ir_write = bm.IRWrite;
        o.pc_write = bm.PCWrite;   o.pc_src = bm.PCSrc;       o.reg_write = bm.RegWrite;
        o.reg_dst = bm.RegDst;     o.mem_to_reg = bm.MemToReg; o.mem_read = bm.MemRead;
        o.mem_write = bm.MemWrite; o.alu_src_a = bm.ALUSrcA;  o.alu_src_b = bm.ALUSrcB;
        o.ext_sel = bm.ExtSel;     o.alu_op = bm.ALUOp;       o.state = bm.State;
        o.halted = bm.Halted;      o.error = bm.Error;
        return o;
    endfunction

    function automatic ctl_t st(input logic [2:0] s);
        ctl_t x = '0;
        x.state  = s;
        x.halted = (s == S_HALT);
        x.error  = (s == S_ERR);
        return x;
    endfunction

    function automatic ctl_t f_if(input logic rdy);
        ctl_t x = st(S_IF);
        x.ins_req  = 1'b1;
        x.ir_write = rdy;
        return x;
    endfunction

    function automatic ctl_t alu(input logic [2:0] s, input logic [2:0] op,
                                 input logic a, input logic b, input logic ext);
        ctl_t x = st(s);
        x.alu_op = op; x.alu_src_a = a; x.alu_src_b = b; x.ext_sel = ext;
        return x;
    endfunction

    // One clock: queue the expectation, compare at the falling edge, advance the model.
    task automatic cyc(input string tag, input ctl_t ex);
        exp_t  x;
        exp_t  got;
        string t;
        ctl_t  o;
        x.ctl  = ex;
        x.ins  = Reset ? 32'd0 : m_ins;
        x.cyc  = Reset ? 32'd0 : m_cyc;
        x.ins3 = Reset ? 3'd0 : m_ins3;
        x.cyc3 = Reset ? 3'd0 : m_cyc3;
        sb_q.push_back(x);
        tag_q.push_back(tag);
        @(negedge CLK);
        got = sb_q.pop_front();
        t   = tag_q.pop_front();
        o   = observed();
        vectors++;
        assert (o === got.ctl) else begin
            miscompares++;
            $error("FAIL %s ctl: observed %h expected %h", t, o, got.ctl);
        end
        vectors++;
        assert (bm.InsCount === got.ins) else begin
            miscompares++;
            $error("FAIL %s InsCount: observed %0d expected %0d", t, bm.InsCount, got.ins);
        end
        vectors++;
        assert (bm.CycleCount === got.cyc) else begin
            miscompares++;
            $error("FAIL %s CycleCount: observed %0d expected %0d", t, bm.CycleCount, got.cyc);
        end
        vectors++;
        assert (bs.InsCount === got.ins3 && bs.CycleCount === got.cyc3) else begin
            miscompares++;
            $error("FAIL %s sat counters: observed %0d/%0d expected %0d/%0d",
                   t, bs.InsCount, bs.CycleCount, got.ins3, got.cyc3);
        end
        if (Reset) begin
            m_ins = 0; m_cyc = 0; m_ins3 = 0; m_cyc3 = 0;
        end else begin
            if (ex.pc_write) begin
                m_ins++;
                if (m_ins3 != 3'd7) m_ins3++;
            end
            if (ex.state != S_HALT && ex.state != S_ERR) begin
                m_cyc++;
                if (m_cyc3 != 3'd7) m_cyc3++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc("reset", st(S_IF));
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; ins_ready = 1'b1;
        repeat (3) cyc("reset_hold", st(S_IF));
        Reset = 1'b0;

        opcode = OP_R; funct = 6'b100000;
        cyc("add_if", f_if(1'b1));
        cyc("add_id", st(S_ID));
        cyc("add_exe", alu(S_EXE, ADD, 1'b0, 1'b0, 1'b1));
        e = st(S_WB); e.reg_write = 1; e.reg_dst = 2'b01; e.pc_write = 1;
        cyc("add_wb", e);

        opcode = OP_LW;
        cyc("lw_if", f_if(1'b1));
        cyc("lw_id", st(S_ID));
        cyc("lw_exe", alu(S_EXE, ADD, 1'b0, 1'b1, 1'b1));
        e = alu(S_MEM, ADD, 1'b0, 1'b1, 1'b1); e.data_req = 1; e.mem_read = 1;
        data_ready = 1'b0;
        repeat (3) cyc("lw_mem_wait", e);
        data_ready = 1'b1;
        cyc("lw_mem_ready_at_limit", e);
        e = st(S_WB); e.reg_write = 1; e.pc_write = 1; e.mem_to_reg = 2'b01;
        cyc("lw_wb", e);

        opcode = OP_BEQ; zero = 1'b1;
        cyc("beq_if", f_if(1'b1));
        cyc("beq_id", st(S_ID));
        e = alu(S_EXE, SUB, 1'b0, 1'b0, 1'b1); e.pc_write = 1; e.pc_src = 2'b01;
        cyc("beq_taken", e);
        opcode = OP_BNE;
        cyc("bne_if", f_if(1'b1));
        cyc("bne_id", st(S_ID));
        e = alu(S_EXE, SUB, 1'b0, 1'b0, 1'b1); e.pc_write = 1; e.pc_src = 2'b00;
        cyc("bne_not_taken", e);

        opcode = OP_ORI;
        cyc("ori_if", f_if(1'b1));
        cyc("ori_id", st(S_ID));
        cyc("ori_exe", alu(S_EXE, ORR, 1'b0, 1'b1, 1'b0));
        e = st(S_WB); e.reg_write = 1; e.pc_write = 1;
        cyc("ori_wb", e);

        opcode = OP_R; funct = 6'b000000;
        cyc("sll_if", f_if(1'b1));
        cyc("sll_id", st(S_ID));
        cyc("sll_exe", alu(S_EXE, SLL, 1'b1, 1'b0, 1'b1));
        e = st(S_WB); e.reg_write = 1; e.reg_dst = 2'b01; e.pc_write = 1;
        cyc("sll_wb", e);

        opcode = OP_SW; ins_ready = 1'b0;
        repeat (2) cyc("sw_if_wait", f_if(1'b0));
        ins_ready = 1'b1;
        cyc("sw_if", f_if(1'b1));
        cyc("sw_id", st(S_ID));
        cyc("sw_exe", alu(S_EXE, ADD, 1'b0, 1'b1, 1'b1));
        e = alu(S_MEM, ADD, 1'b0, 1'b1, 1'b1); e.data_req = 1; e.mem_write = 1; e.pc_write = 1;
        cyc("sw_mem", e);

        opcode = OP_JAL;
        cyc("jal_if", f_if(1'b1));
        e = st(S_ID); e.pc_write = 1; e.pc_src = 2'b10; e.reg_write = 1;
        e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
        cyc("jal_id", e);
        opcode = OP_J;
        cyc("j_if", f_if(1'b1));
        e = st(S_ID); e.pc_write = 1; e.pc_src = 2'b10;
        cyc("j_id", e);

        opcode = OP_R; funct = 6'b100000;
        cyc("abort_if", f_if(1'b1));
        cyc("abort_id", st(S_ID));
        Reset = 1'b1;
        cyc("abort_reset_in_exe", st(S_IF));
        Reset = 1'b0;

        ins_ready = 1'b0;
        repeat (4) cyc("timeout_if", f_if(1'b0));
        cyc("timeout_err", st(S_ERR));
        ins_ready = 1'b1;
        repeat (2) cyc("err_sticky", st(S_ERR));
        vectors++;
        assert (bm.CycleCount === 32'd4) else begin
            miscompares++;
            $error("FAIL timeout_cycle_freeze: observed %0d expected 4", bm.CycleCount);
        end

        do_reset();
        opcode = OP_HALT;
        cyc("halt_if", f_if(1'b1));
        cyc("halt_id", st(S_ID));
        repeat (3) cyc("halted", st(S_HALT));
        do_reset();
        cyc("after_halt_if", f_if(1'b1));

        opcode = 6'b010000;
        cyc("badop_id", st(S_ID));
        cyc("badop_err", st(S_ERR));
        do_reset();
        opcode = OP_R; funct = 6'b111111;
        cyc("badfn_if", f_if(1'b1));
        cyc("badfn_id", st(S_ID));
        cyc("badfn_err", st(S_ERR));

        do_reset();
        opcode = OP_SW; data_ready = 1'b0;
        cyc("memto_if", f_if(1'b1));
        cyc("memto_id", st(S_ID));
        cyc("memto_exe", alu(S_EXE, ADD, 1'b0, 1'b1, 1'b1));
        e = alu(S_MEM, ADD, 1'b0, 1'b1, 1'b1); e.data_req = 1; e.mem_write = 1;
        repeat (4) cyc("memto_wait", e);
        cyc("memto_err", st(S_ERR));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
